led_uart_reporter: RTL and testbench
====================================

# led_uart_reporter

Serial status reporter that sits directly downstream of the LED pattern stage. It watches the 8-bit `LEDS` bus and, whenever the value changes, transmits it on `TXD` as a 10-byte ASCII line: eight characters '0'/'1', MSB first, followed by CR LF. Framing is 8N1 UART at a fixed baud rate, so LED activity can be logged from a host terminal alongside the on-board LEDs.

## Interface
- `CLK_FREQ_HZ`, default 10_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: UART bit rate.
- `CLKS_PER_BIT`, default `CLK_FREQ_HZ/BAUD` (integer division, truncated): cycles per UART bit. Must be ≥ 2; elaboration fails otherwise.
- `CLK`, input, 1: system clock. Single clock domain, rising edge.
- `RESET`, input, 1: synchronous, active-high reset.
- `LEDS`, input, 8: LED pattern from the upstream stage. Synchronous to `CLK`.
- `TXD`, output, 1: UART serial out. Registered; idles high.
- `BUSY`, output, 1: high while a message is being transmitted.

## Operation
- **Reset values:**
  - `TXD` = 1.
  - `BUSY` = 0.
  - FSM = IDLE.
  - `last_rep` (last reported value) = 8'h00.
  - Byte index and bit index = 0.
  - Baud counter = 0.
- **FSM states:** IDLE → START → DATA → STOP, then STOP → START for the next byte, or STOP → IDLE after byte 9.
- **IDLE:**
  - If `LEDS != last_rep`, capture `LEDS` into `snap` and `last_rep`, set byte index to 0, and go to START.
  - Otherwise stay in IDLE with `TXD` = 1.
- **Byte encoding:**
  - Byte i (0..7) = 8'h30 + `snap[7-i]`, so '1' = 8'h31 and '0' = 8'h30.
  - Byte 8 = 8'h0D (CR).
  - Byte 9 = 8'h0A (LF).
- **START:** `TXD` = 0 for `CLKS_PER_BIT` cycles.
- **DATA:** 8 bits, LSB first, each held for `CLKS_PER_BIT` cycles.
- **STOP:** `TXD` = 1 for `CLKS_PER_BIT` cycles.
  - After bytes 0..8, go straight to START with no extra idle cycles.
  - After byte 9, go to IDLE.
- **Changes during a message:**
  - `LEDS` changes while not in IDLE are not queued.
  - On the return to IDLE, `LEDS` is compared against `last_rep`. Only the current value is reported; intermediate values are lost.
  - A change that reverts to `last_rep` before the message ends produces no message.
- **Reset mid-operation:** abort immediately and return every register to its reset value. No partial byte or stop bit is completed.

## Timing
- **Message start:** if rising edge k samples IDLE with `LEDS != last_rep`:
  - `TXD` falls and `BUSY` rises at edge k+1.
  - Latency from the sampling edge to the start bit is 1 cycle.
- **Bit width:** every bit lasts exactly `CLKS_PER_BIT` cycles.
- **Frame and message length:**
  - One frame is 10 × `CLKS_PER_BIT` cycles.
  - One message is 100 × `CLKS_PER_BIT` cycles.
- **BUSY:** stays high continuously from edge k+1 until the last cycle of the LF stop bit. It falls on the edge that enters IDLE.
- **Back-to-back messages:**
  - IDLE lasts at least 1 cycle between messages.
  - If a change is pending, the next start bit begins 1 cycle after `BUSY` falls.
  - `BUSY` shows a 1-cycle low pulse between the two messages.
- **Wrap-around:**
  - The baud counter counts 0..`CLKS_PER_BIT`-1 and wraps.
  - The bit index counts 0..7.
  - The byte index counts 0..9.
  - No counter is compared outside its range.
- **Output glitches:** `TXD` comes directly from a flop and never glitches.

## Test plan
Bench parameters: `CLK_FREQ_HZ`=1000, `BAUD`=100, so `CLKS_PER_BIT`=10.

1. Hold `RESET` high for 3 cycles, release, keep `LEDS`=8'h00 for 2000 cycles → `TXD`=1 and `BUSY`=0 throughout.
2. Set `LEDS`=8'b11100000 → start bit 1 cycle after the sampling edge; each bit exactly 10 cycles. Decoded bytes are 31 31 31 30 30 30 30 30 0D 0A. `BUSY` is high for exactly 1000 cycles.
3. Report 8'h01, then during that message set `LEDS`=8'h02 and then 8'h04 → the second message is "00000100\r\n" only. Its start bit begins 1 cycle after `BUSY` falls, with a 1-cycle `BUSY` low gap.
4. Report 8'h01, then during that message set `LEDS`=8'h80 and back to 8'h01 before the LF stop bit ends → no second message. `TXD` stays high for 1000 cycles.
5. Assert `RESET` for 1 cycle mid-DATA of byte 3 while `LEDS`=8'h05 → `TXD`=1 and `BUSY`=0 on the next edge. One cycle after release, a full "00000101\r\n" message starts.
6. Bit-order check with `LEDS`=8'h80 → byte 0 = 8'h31 is driven as bits 1,0,0,0,1,1,0,0 (LSB first), preceded by a start bit of 0 and followed by a stop bit of 1.

Source files
------------

// File: rtl/led_uart_reporter.sv
//==============================================================================
// Module   : led_uart_reporter
// Summary  : Sends the 8-bit LED pattern as an ASCII "bbbbbbbb\r\n" line over
//            an 8N1 UART each time the pattern changes.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module led_uart_reporter #(
    parameter int CLK_FREQ_HZ  = 10_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] LEDS,
    output logic       TXD,
    output logic       BUSY
);

    localparam int                 c_cnt_w    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [3:0]         c_last_byte = 4'd9;

    generate
        if (CLKS_PER_BIT < 2) begin : g_cpb_check
            $error("led_uart_reporter: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             r_state;
    logic [7:0]         r_last_rep;
    logic [7:0]         r_snap;
    logic [3:0]         r_byte_idx;
    logic [2:0]         r_bit_idx;
    logic [c_cnt_w-1:0] r_baud_cnt;
    logic               r_txd;
    logic               r_busy;

    logic [7:0]         w_cur_byte;
    logic [2:0]         w_bit_nxt;
    logic               w_baud_done;

    // Bytes 0..7 are the snapshot bits MSB first as '0'/'1', then CR, LF.
    always_comb begin
        w_cur_byte = 8'h0A;
        if (r_byte_idx < 4'd8) begin
            w_cur_byte = 8'h30 | {7'd0, r_snap[3'd7 - r_byte_idx[2:0]]};
        end else if (r_byte_idx == 4'd8) begin
            w_cur_byte = 8'h0D;
        end
    end

    assign w_bit_nxt   = r_bit_idx + 3'd1;
    assign w_baud_done = (r_baud_cnt == c_cnt_last);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_last_rep <= 8'h00;
            r_snap     <= 8'h00;
            r_byte_idx <= 4'd0;
            r_bit_idx  <= 3'd0;
            r_baud_cnt <= '0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_txd      <= 1'b1;
                    r_busy     <= 1'b0;
                    r_baud_cnt <= '0;
                    if (LEDS != r_last_rep) begin
                        r_snap     <= LEDS;
                        r_last_rep <= LEDS;
                        r_byte_idx <= 4'd0;
                        r_bit_idx  <= 3'd0;
                        r_txd      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_START;
                    end
                end

                S_START: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= 3'd0;
                        r_txd      <= w_cur_byte[0];
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_cnt_one;
                    end
                end

                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= w_bit_nxt;
                            r_txd     <= w_cur_byte[w_bit_nxt];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_cnt_one;
                    end
                end

                S_STOP: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        if (r_byte_idx == c_last_byte) begin
                            // BUSY drops on the edge that enters IDLE.
                            r_busy  <= 1'b0;
                            r_txd   <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 4'd1;
                            r_txd      <= 1'b0;
                            r_state    <= S_START;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_cnt_one;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign TXD  = r_txd;
    assign BUSY = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_led_uart_reporter.sv
//==============================================================================
// Module   : tb_led_uart_reporter
// Summary  : Self-checking bench for led_uart_reporter (CLKS_PER_BIT = 10).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_led_uart_reporter;

    localparam int CPB = 10;
    localparam int MSG = 100 * CPB;

    logic       CLK;
    logic       RESET;
    logic [7:0] LEDS;
    logic       TXD;
    logic       BUSY;

    led_uart_reporter #(
        .CLK_FREQ_HZ  (1000),
        .BAUD         (100),
        .CLKS_PER_BIT (1000 / 100)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .LEDS  (LEDS),
        .TXD   (TXD),
        .BUSY  (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: message position in cycles since the start bit.
    logic       m_busy = 1'b0;
    int         m_t    = 0;
    logic [7:0] m_last = 8'h00;
    logic [7:0] m_snap = 8'h00;

    logic       rec [0:MSG-1];
    logic [7:0] dec [0:9];
    logic [7:0] exp_e0 [0:9];

    typedef struct {
        logic       rst;
        logic [7:0] leds;
        int         cycles;
        logic       exp_txd;
        logic       exp_busy;
    } vec_t;

    vec_t tbl [0:17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] char_of(input logic [7:0] v, input int b);
        if (b < 8)       return v[7-b] ? 8'h31 : 8'h30;
        else if (b == 8) return 8'h0D;
        else             return 8'h0A;
    endfunction

    function automatic logic exp_txd();
        int b;
        int f;
        logic [7:0] v;
        if (!m_busy) return 1'b1;
        b = m_t / (10 * CPB);
        f = (m_t % (10 * CPB)) / CPB;
        if (f == 0) return 1'b0;
        if (f == 9) return 1'b1;
        v = char_of(m_snap, b);
        return v[f-1];
    endfunction

    task automatic model_step();
        if (RESET) begin
            m_busy = 1'b0;
            m_t    = 0;
            m_last = 8'h00;
        end else if (!m_busy) begin
            if (LEDS != m_last) begin
                m_snap = LEDS;
                m_last = LEDS;
                m_busy = 1'b1;
                m_t    = 0;
            end
        end else begin
            m_t++;
            if (m_t == MSG) m_busy = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        check("cyc_txd",  32'(TXD),  32'(exp_txd()));
        check("cyc_busy", 32'(BUSY), 32'(m_busy));
    endtask

    task automatic wait_busy(input logic val, input int bound, input string tag);
        int n;
        n = 0;
        while (BUSY !== val && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(BUSY), 32'(val));
    endtask

    // Called right after the edge that raised BUSY; records and decodes one message.
    task automatic capture_msg(input string tag);
        int hi;
        hi = 0;
        for (int i = 0; i < MSG; i++) begin
            rec[i] = TXD;
            if (BUSY) hi++;
            tick();
        end
        check({tag, "_busy_len"}, 32'(hi), 32'(MSG));
        check({tag, "_busy_fall"}, 32'(BUSY), 32'd0);
        for (int b = 0; b < 10; b++) begin
            check({tag, "_start_bit"}, 32'(rec[b*10*CPB + CPB/2]), 32'd0);
            check({tag, "_stop_bit"},  32'(rec[b*10*CPB + 9*CPB + CPB/2]), 32'd1);
            for (int j = 0; j < 8; j++) dec[b][j] = rec[b*10*CPB + (j+1)*CPB + CPB/2];
        end
    endtask

    task automatic check_msg(input string tag, input logic [7:0] v);
        for (int b = 0; b < 10; b++) check({tag, "_byte"}, 32'(dec[b]), 32'(char_of(v, b)));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        RESET = 1'b1;
        LEDS  = 8'h00;

        exp_e0 = '{8'h31, 8'h31, 8'h31, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};

        // Reset, long quiet idle, then 8'h80 walked bit by bit through byte 0.
        tbl[0]  = '{1'b1, 8'h00, 3,    1'b1, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 2000, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 8'h80, 1,    1'b0, 1'b1};
        tbl[3]  = '{1'b0, 8'h80, 9,    1'b0, 1'b1};
        tbl[4]  = '{1'b0, 8'h80, 1,    1'b1, 1'b1};
        tbl[5]  = '{1'b0, 8'h80, 10,   1'b0, 1'b1};
        tbl[6]  = '{1'b0, 8'h80, 10,   1'b0, 1'b1};
        tbl[7]  = '{1'b0, 8'h80, 10,   1'b0, 1'b1};
        tbl[8]  = '{1'b0, 8'h80, 10,   1'b1, 1'b1};
        tbl[9]  = '{1'b0, 8'h80, 10,   1'b1, 1'b1};
        tbl[10] = '{1'b0, 8'h80, 10,   1'b0, 1'b1};
        tbl[11] = '{1'b0, 8'h80, 10,   1'b0, 1'b1};
        tbl[12] = '{1'b0, 8'h80, 10,   1'b1, 1'b1};
        tbl[13] = '{1'b0, 8'h80, 10,   1'b0, 1'b1};
        tbl[14] = '{1'b0, 8'h80, 10,   1'b0, 1'b1};
        tbl[15] = '{1'b0, 8'h80, 889,  1'b1, 1'b1};
        tbl[16] = '{1'b0, 8'h80, 1,    1'b1, 1'b0};
        tbl[17] = '{1'b0, 8'h80, 1,    1'b1, 1'b0};

        for (int r = 0; r < 18; r++) begin
            RESET = tbl[r].rst;
            LEDS  = tbl[r].leds;
            repeat (tbl[r].cycles) tick();
            check($sformatf("vec%0d_txd", r),  32'(TXD),  32'(tbl[r].exp_txd));
            check($sformatf("vec%0d_busy", r), 32'(BUSY), 32'(tbl[r].exp_busy));
        end

        // 8'b11100000 decoded byte by byte.
        LEDS = 8'hE0;
        tick();
        check("e0_start_latency", 32'({TXD, BUSY}), 32'(2'b01));
        capture_msg("e0");
        for (int b = 0; b < 10; b++) check("e0_byte", 32'(dec[b]), 32'(exp_e0[b]));

        // Changes during a message: only the final value is reported.
        LEDS = 8'h01;
        tick();
        check("b_start", 32'(BUSY), 32'd1);
        repeat (200) tick();
        LEDS = 8'h02;
        repeat (100) tick();
        LEDS = 8'h04;
        wait_busy(1'b0, 1200, "b_first_end");
        tick();
        check("b_gap_restart", 32'({TXD, BUSY}), 32'(2'b01));
        capture_msg("b2");
        check_msg("b2", 8'h04);

        // Change that reverts before the end produces no message.
        LEDS = 8'h01;
        tick();
        check("c_start", 32'(BUSY), 32'd1);
        repeat (300) tick();
        LEDS = 8'h80;
        repeat (300) tick();
        LEDS = 8'h01;
        wait_busy(1'b0, 1200, "c_end");
        bad = 0;
        repeat (MSG) begin
            tick();
            if (TXD !== 1'b1 || BUSY !== 1'b0) bad++;
        end
        check("c_no_second_msg", 32'(bad), 32'd0);

        // Reset in the middle of byte 3 data bits.
        LEDS = 8'h05;
        tick();
        check("d_start", 32'(BUSY), 32'd1);
        repeat (350) tick();
        RESET = 1'b1;
        tick();
        check("d_reset_mid", 32'({TXD, BUSY}), 32'(2'b10));
        RESET = 1'b0;
        tick();
        check("d_restart", 32'({TXD, BUSY}), 32'(2'b01));
        capture_msg("d");
        check_msg("d", 8'h05);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                RESET = 1'b1;
                tick();
                RESET = 1'b0;
            end
            case ($urandom_range(0, 4))
                0:       LEDS = 8'h00;
                1:       LEDS = 8'h01;
                2:       LEDS = 8'h80;
                3:       LEDS = 8'hFF;
                default: LEDS = 8'($urandom);
            endcase
            repeat ($urandom_range(1, 700)) tick();
        end
        wait_busy(1'b0, 1200, "rand_drain");
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
